// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a classic 5-stage pipeline. Each cycle it selects one
// action with fixed priority (reset > memory wait > taken branch > load-use >
// run) and drives the pipeline-register enables, flushes and the MEM/WB
// bubble combinationally from the current inputs. It also records the
// selected action, counts stall cycles and flags data-memory wait overruns.
//
// Parameters
//   TIMEOUT  consecutive memory-wait cycles after which mem_timeout is set
//   CNT_W    width of the stall performance counter
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous, active-high reset
//   id_rs, id_rt   source register fields of the instruction in ID
//   ex_memread     the instruction in EX is a load
//   ex_rt          destination register of the load in EX
//   branch_taken   a branch resolved taken this cycle
//   mem_req        MEM stage is accessing data memory
//   mem_ready      data memory completes the access this cycle
//   pc_we          PC write enable
//   if_id_we       IF/ID write enable
//   if_id_flush    load a NOP into IF/ID
//   id_ex_we       ID/EX write enable
//   id_ex_flush    load a control-zero bubble into ID/EX
//   ex_mem_we      EX/MEM write enable
//   mem_wb_bubble  force WB=0 into MEM/WB
//   state          action selected in the previous cycle
//                  (RUN=0, MEM_WAIT=1, LU_STALL=2, FLUSH=3)
//   stall_cnt      saturating count of cycles with pc_we=0 (reset excluded)
//   mem_timeout    sticky memory-wait overrun flag, cleared only by rst
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    ACT_RUN      = 2'd0,
    ACT_MEM_WAIT = 2'd1,
    ACT_LU_STALL = 2'd2,
    ACT_FLUSH    = 2'd3
  } action_e;

  // Wide enough to hold TIMEOUT itself; the counter parks there.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  action_e           action;
  action_e           state_q;
  logic              mem_wait;
  logic              load_use;
  logic [WAIT_W-1:0] wait_cnt;

  // A ready in the same cycle as the request is a zero-wait access.
  assign mem_wait = mem_req & ~mem_ready;

  // Register 0 is hard-wired zero, so a load targeting it never creates a
  // real dependency.
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Action select and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output gets its default before the priority chain, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    action        = ACT_RUN;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;

    if (rst) begin
      // Freeze all registers and hold bubbles in every flushable stage.
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_we      = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (mem_wait) begin
      // Whole front of the pipe freezes; WB sees a bubble until data arrives.
      action        = ACT_MEM_WAIT;
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      // Checked before load-use: the dependent instruction is squashed here.
      action        = ACT_FLUSH;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID; ID/EX is written with the bubble so the load moves
      // on to MEM and the dependent instruction retries next cycle.
      action        = ACT_LU_STALL;
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered action, stall counter, wait counter and timeout flag
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACT_RUN;
      stall_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= action;

      if (!pc_we && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      if (mem_wait) begin
        if (wait_cnt != WAIT_W'(TIMEOUT)) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        // The edge that brings the count to TIMEOUT raises the flag; the
        // stall itself is not affected.
        if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          mem_timeout <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Drives two copies of pipeline_hazard_ctrl from the same inputs: one with the
// default counter width and one with CNT_W=4 for the saturation case. A
// reference model built from the action table (priority lookup, integer
// counters clamped with min()) predicts every output each cycle. Inputs change
// on the falling edge; combinational outputs are sampled 1 ns later and
// registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;
  localparam int CNT_WS  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, branch_taken, mem_req, mem_ready;

  logic             pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic             ex_mem_we, mem_wb_bubble, mem_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  logic              s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_we;
  logic              s_id_ex_flush, s_ex_mem_we, s_mem_wb_bubble, s_mem_timeout;
  logic [1:0]        s_state;
  logic [CNT_WS-1:0] s_stall_cnt;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
    .mem_wb_bubble(mem_wb_bubble), .state(state), .stall_cnt(stall_cnt),
    .mem_timeout(mem_timeout)
  );

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_WS)) dut_s (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(s_pc_we), .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush),
    .id_ex_we(s_id_ex_we), .id_ex_flush(s_id_ex_flush), .ex_mem_we(s_ex_mem_we),
    .mem_wb_bubble(s_mem_wb_bubble), .state(s_state), .stall_cnt(s_stall_cnt),
    .mem_timeout(s_mem_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int exp_state = 0;
  int exp_cnt   = 0;
  int exp_cnts  = 0;
  int exp_wait  = 0;
  bit exp_to    = 1'b0;

  // Action codes: -1 reset, 0 run, 1 memory wait, 2 load-use, 3 flush.
  function automatic int model_action();
    bit lu;
    lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    if (rst)                    return -1;
    if (mem_req && !mem_ready)  return 1;
    if (branch_taken)           return 3;
    if (lu)                     return 2;
    return 0;
  endfunction

  // Control vector {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
  // ex_mem_we, mem_wb_bubble} for each action, straight from the action table.
  function automatic logic [6:0] model_ctrl(input int act);
    case (act)
      -1:      return 7'b0010101;
      1:       return 7'b0000001;
      3:       return 7'b1111110;
      2:       return 7'b0001110;
      default: return 7'b1101010;
    endcase
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Compare the combinational outputs of both instances for the current inputs.
  task automatic settle(input string name);
    logic [6:0] exp_v, got_v, got_s;
    #1;
    exp_v = model_ctrl(model_action());
    got_v = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble};
    got_s = {s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_we, s_id_ex_flush,
             s_ex_mem_we, s_mem_wb_bubble};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s ctrl: got %b expected %b", name, got_v, exp_v);
    end
    n_checks++;
    if (got_s !== exp_v) begin
      n_fail++;
      $display("FAIL %s ctrl_w4: got %b expected %b", name, got_s, exp_v);
    end
  endtask

  // Advance one clock, update the model and compare all registered outputs.
  task automatic clock(input string name);
    int act;
    act = model_action();
    @(posedge clk);
    if (act < 0) begin
      exp_state = 0; exp_cnt = 0; exp_cnts = 0; exp_wait = 0; exp_to = 1'b0;
    end else begin
      exp_state = act;
      if (model_ctrl(act)[6] == 1'b0) begin
        exp_cnt  = min_int(exp_cnt + 1, (1 << CNT_W) - 1);
        exp_cnts = min_int(exp_cnts + 1, (1 << CNT_WS) - 1);
      end
      if (act == 1) begin
        exp_wait++;
        if (exp_wait >= TIMEOUT) exp_to = 1'b1;
      end else begin
        exp_wait = 0;
      end
    end
    #1;
    n_checks++;
    if (state !== 2'(exp_state) || s_state !== 2'(exp_state)) begin
      n_fail++;
      $display("FAIL %s state: got %0d/%0d expected %0d", name, state, s_state, exp_state);
    end
    n_checks++;
    if (stall_cnt !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt, exp_cnt);
    end
    n_checks++;
    if (s_stall_cnt !== CNT_WS'(exp_cnts)) begin
      n_fail++;
      $display("FAIL %s stall_cnt_w4: got %0d expected %0d", name, s_stall_cnt, exp_cnts);
    end
    n_checks++;
    if (mem_timeout !== exp_to || s_mem_timeout !== exp_to) begin
      n_fail++;
      $display("FAIL %s mem_timeout: got %b/%b expected %b", name, mem_timeout,
               s_mem_timeout, exp_to);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    ex_memread = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    settle("reset");
    clock("reset");
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Reset must dominate a concurrent memory wait and load-use.
    rst = 1'b1;
    mem_req = 1'b1; ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    for (int i = 0; i < 2; i++) begin
      settle("test_reset");
      n_checks++;
      if ({pc_we, if_id_we, id_ex_we, ex_mem_we} !== 4'b0000 ||
          {if_id_flush, id_ex_flush, mem_wb_bubble} !== 3'b111) begin
        n_fail++;
        $display("FAIL test_reset outputs: got we=%b%b%b%b fl/bub=%b%b%b expected 0000/111",
                 pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_bubble);
      end
      clock("test_reset");
    end
    n_checks++;
    if (state !== 2'd0 || stall_cnt !== '0 || mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL test_reset regs: got state=%0d cnt=%0d to=%b expected 0/0/0",
               state, stall_cnt, mem_timeout);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
    settle("test_load_use");
    n_checks++;
    if (pc_we !== 1'b0 || if_id_we !== 1'b0 || id_ex_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL test_load_use ctrl: got pc_we=%b if_id_we=%b id_ex_flush=%b expected 0/0/1",
               pc_we, if_id_we, id_ex_flush);
    end
    clock("test_load_use");
    n_checks++;
    if (state !== 2'd2 || stall_cnt !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL test_load_use regs: got state=%0d cnt=%0d expected 2/1", state, stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_rt_zero();
    ex_memread = 1'b1; ex_rt = 5'd0; id_rt = 5'd0; id_rs = 5'd0;
    settle("test_rt_zero");
    n_checks++;
    if ({pc_we, if_id_we, id_ex_we, ex_mem_we} !== 4'b1111 ||
        {if_id_flush, id_ex_flush} !== 2'b00) begin
      n_fail++;
      $display("FAIL test_rt_zero ctrl: got we=%b%b%b%b flush=%b%b expected 1111/00",
               pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush);
    end
    clock("test_rt_zero");
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL test_rt_zero state: got %0d expected 0", state);
    end
    idle_inputs();
  endtask

  task automatic test_branch_over_lu();
    int cnt0;
    cnt0 = exp_cnt;
    branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd1;
    settle("test_branch_over_lu");
    n_checks++;
    if (pc_we !== 1'b1 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL test_branch_over_lu ctrl: got pc_we=%b if_id_flush=%b id_ex_flush=%b expected 1/1/1",
               pc_we, if_id_flush, id_ex_flush);
    end
    clock("test_branch_over_lu");
    n_checks++;
    if (state !== 2'd3 || stall_cnt !== CNT_W'(cnt0)) begin
      n_fail++;
      $display("FAIL test_branch_over_lu regs: got state=%0d cnt=%0d expected 3/%0d",
               state, stall_cnt, cnt0);
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    int cnt0;
    cnt0 = exp_cnt;
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle("test_mem_wait");
      n_checks++;
      if ({pc_we, if_id_we, id_ex_we, ex_mem_we} !== 4'b0000 || mem_wb_bubble !== 1'b1) begin
        n_fail++;
        $display("FAIL test_mem_wait cycle %0d: got we=%b%b%b%b bubble=%b expected 0000/1",
                 i, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_bubble);
      end
      clock("test_mem_wait");
    end
    mem_ready = 1'b1;
    settle("test_mem_wait_release");
    n_checks++;
    if ({pc_we, if_id_we, id_ex_we, ex_mem_we} !== 4'b1111 || mem_wb_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL test_mem_wait release: got we=%b%b%b%b bubble=%b expected 1111/0",
               pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_bubble);
    end
    clock("test_mem_wait_release");
    n_checks++;
    if (stall_cnt !== CNT_W'(cnt0 + 3)) begin
      n_fail++;
      $display("FAIL test_mem_wait stall_cnt: got %0d expected %0d", stall_cnt, cnt0 + 3);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      settle("test_timeout");
      clock("test_timeout");
      n_checks++;
      if (mem_timeout !== (i == TIMEOUT)) begin
        n_fail++;
        $display("FAIL test_timeout after edge %0d: got %b expected %b",
                 i, mem_timeout, (i == TIMEOUT));
      end
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle("test_timeout_hold");
      clock("test_timeout_hold");
      n_checks++;
      if (mem_timeout !== 1'b1) begin
        n_fail++;
        $display("FAIL test_timeout hold: got %b expected 1", mem_timeout);
      end
    end
    do_reset();
    n_checks++;
    if (mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL test_timeout clear: got %b expected 0", mem_timeout);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst          = ($urandom_range(0, 24) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rt        = 5'($urandom_range(0, 3));
      ex_memread   = 1'($urandom);
      branch_taken = ($urandom_range(0, 3) == 0);
      mem_req      = 1'($urandom);
      // Alternate between short and long memory latencies so waits of
      // TIMEOUT cycles and more happen in some blocks.
      if ((i / 60) % 2 == 1) begin
        mem_req   = 1'b1;
        mem_ready = ($urandom_range(0, 19) == 0);
      end else begin
        mem_ready = 1'($urandom);
      end
      settle("test_random");
      clock("test_random");
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      settle("test_saturation");
      clock("test_saturation");
    end
    n_checks++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== CNT_W'(20)) begin
      n_fail++;
      $display("FAIL test_saturation count: got w4=%0d w16=%0d expected 15/20",
               s_stall_cnt, stall_cnt);
    end
    do_reset();
    n_checks++;
    if (s_stall_cnt !== '0 || stall_cnt !== '0 || state !== 2'd0 ||
        s_state !== 2'd0 || mem_timeout !== 1'b0 || s_mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL test_saturation reset: got cnt=%0d/%0d state=%0d/%0d to=%b/%b expected all 0",
               s_stall_cnt, stall_cnt, s_state, state, s_mem_timeout, mem_timeout);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_rt_zero();
    test_branch_over_lu();
    test_mem_wait();
    test_timeout();
    test_random(600);
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
